// File: rtl/riscv_pkg.sv
// Shared definitions for the single-cycle RISC-V core: instruction memory
// size, boot loader state encoding and a byte-lane selection helper.
package riscv_pkg;

    localparam int IMEM_BYTES = 88;

    typedef enum logic [1:0] {
        LD_IDLE      = 2'd0,
        LD_WAIT_WORD = 2'd1,
        LD_WRITE     = 2'd2,
        LD_DONE      = 2'd3
    } loader_state_t;

    // Little-endian byte lane of a 32-bit word: lane 0 is bits [7:0].
    function automatic logic [7:0] word_byte(input logic [31:0] word, input logic [1:0] lane);
        logic [7:0] b;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/imem_boot_loader.sv
// Boot-time loader for the byte-addressed instruction memory. Takes 32-bit
// words from a valid/ready stream, writes each as four little-endian bytes,
// and keeps the core in reset until the requested image is complete.
module imem_boot_loader
    import riscv_pkg::*;
#(
    parameter int MEM_BYTES = IMEM_BYTES,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = $clog2(MEM_BYTES / 4 + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [CNT_W-1:0]  load_words,
    input  logic              in_valid,
    input  logic [31:0]       in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    // Byte count of the request is computed two bits wider so it never wraps.
    localparam int REQ_W = CNT_W + 2;

    loader_state_t     state_r;
    logic [CNT_W-1:0]  count_r;
    logic [ADDR_W-1:0] word_addr_r;
    logic [1:0]        lane_r;
    logic [31:0]       word_r;
    logic              err_r;

    logic [REQ_W-1:0]  req_bytes_s;
    logic              too_big_s;

    assign req_bytes_s = {load_words, 2'b00};
    assign too_big_s   = (req_bytes_s > REQ_W'(MEM_BYTES));

    // Load sequencer: state, word address, byte lane, remaining count, error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= LD_IDLE;
            count_r     <= '0;
            word_addr_r <= '0;
            lane_r      <= 2'd0;
            word_r      <= 32'h0000_0000;
            err_r       <= 1'b0;
        end else if (abort) begin
            // Abort beats start; a partially written word is left in memory.
            state_r <= LD_IDLE;
        end else begin
            case (state_r)
                LD_IDLE, LD_DONE: begin
                    if (start) begin
                        if (too_big_s) begin
                            // Rejected request: flag it and leave state untouched.
                            err_r <= 1'b1;
                        end else begin
                            err_r       <= 1'b0;
                            word_addr_r <= '0;
                            lane_r      <= 2'd0;
                            count_r     <= load_words;
                            state_r     <= (load_words == CNT_W'(0)) ? LD_DONE : LD_WAIT_WORD;
                        end
                    end
                end
                LD_WAIT_WORD: begin
                    if (in_valid) begin
                        word_r  <= in_data;
                        lane_r  <= 2'd0;
                        state_r <= LD_WRITE;
                    end
                end
                LD_WRITE: begin
                    if (lane_r == 2'd3) begin
                        lane_r      <= 2'd0;
                        word_addr_r <= word_addr_r + ADDR_W'(4);
                        count_r     <= count_r - CNT_W'(1);
                        state_r     <= (count_r == CNT_W'(1)) ? LD_DONE : LD_WAIT_WORD;
                    end else begin
                        lane_r <= lane_r + 2'd1;
                    end
                end
                default: begin
                    state_r <= LD_IDLE;
                end
            endcase
        end
    end

    // Output decode from registered state; address/data are forced to 0 outside writes.
    always_comb begin
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = 8'h00;
        busy      = 1'b0;
        done      = 1'b0;
        cpu_rst_n = 1'b0;
        err       = err_r;
        case (state_r)
            LD_IDLE: begin
                busy = 1'b0;
            end
            LD_WAIT_WORD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            LD_WRITE: begin
                busy      = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = word_addr_r + ADDR_W'(lane_r);
                mem_wdata = word_byte(word_r, lane_r);
            end
            LD_DONE: begin
                done      = 1'b1;
                cpu_rst_n = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
